// File: rtl/tb_run_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_run_controller
//  Description : Run controller for the top-level processor bench. Sequences
//                the DUT reset, counts run cycles and committed instructions,
//                and detects termination on halt, global timeout, commit
//                stall or error (with a post-error drain window). Reports a
//                sticky done flag plus a status code for the bench verdict.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_run_controller #(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 10000000,
    parameter int STALL_CYCLES   = 10000,
    parameter int DRAIN_CYCLES   = 5,
    parameter int NUM_ERR        = 3,
    parameter int CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               commit_valid,
    input  logic               halt,
    input  logic [NUM_ERR-1:0] err,
    output logic               dut_rst,
    output logic               run,
    output logic               done,
    output logic [2:0]         status,
    output logic [NUM_ERR-1:0] err_src,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   commit_count
);

    // ------------------------------------------------------------------
    // Counter widths; every counter is at least one bit wide even when
    // its feature is disabled so the declarations stay legal.
    // ------------------------------------------------------------------
    localparam int c_RST_W   = (RST_CYCLES   > 1) ? $clog2(RST_CYCLES + 1)   : 1;
    localparam int c_STALL_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
    localparam int c_DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    // Terminal counter values: the event fires on the cycle whose counter
    // still holds the "last" value, so the transition lands on that edge.
    localparam logic [c_RST_W-1:0]   c_RST_LAST   = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_STALL_W-1:0] c_STALL_LAST =
        c_STALL_W'((STALL_CYCLES > 0) ? (STALL_CYCLES - 1) : 0);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST =
        c_DRAIN_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0]     c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [CNT_W-1:0]     c_CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     c_CNT_ONE   = CNT_W'(1);
    localparam logic [c_RST_W-1:0]   c_RST_ONE   = c_RST_W'(1);
    localparam logic [c_STALL_W-1:0] c_STALL_MAX = {c_STALL_W{1'b1}};
    localparam logic [c_STALL_W-1:0] c_STALL_ONE = c_STALL_W'(1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE = c_DRAIN_W'(1);

    localparam bit c_STALL_EN = (STALL_CYCLES != 0);
    localparam bit c_DRAIN_EN = (DRAIN_CYCLES != 0);

    // Status codes
    localparam logic [2:0] c_ST_RUNNING = 3'd0;
    localparam logic [2:0] c_ST_PASS    = 3'd1;
    localparam logic [2:0] c_ST_TIMEOUT = 3'd2;
    localparam logic [2:0] c_ST_STALL   = 3'd3;
    localparam logic [2:0] c_ST_ERROR   = 3'd4;

    // FSM encoding
    localparam logic [1:0] c_S_RESET = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_next_state;

    logic [c_RST_W-1:0]   r_rst_cnt;
    logic [c_STALL_W-1:0] r_stall_cnt;
    logic [c_DRAIN_W-1:0] r_drain_cnt;
    logic [CNT_W-1:0]     r_cycle_cnt;
    logic [CNT_W-1:0]     r_commit_cnt;

    logic                 r_dut_rst;
    logic                 r_run;
    logic                 r_done;
    logic [2:0]           r_status;
    logic [NUM_ERR-1:0]   r_err_src;

    logic                 w_dut_rst_nxt;
    logic                 w_run_nxt;
    logic                 w_done_nxt;

    // ------------------------------------------------------------------
    // Terminal event decode, evaluated on this cycle's inputs and counters
    // ------------------------------------------------------------------
    logic w_in_run;
    logic w_counting;
    logic w_ev_err;
    logic w_ev_stall;
    logic w_ev_timeout;
    logic w_rst_last;
    logic w_drain_last;

    assign w_in_run     = (r_state == c_S_RUN);
    assign w_counting   = (r_state == c_S_RUN) || (r_state == c_S_DRAIN);
    assign w_ev_err     = |err;
    assign w_ev_stall   = c_STALL_EN && !commit_valid && (r_stall_cnt == c_STALL_LAST);
    assign w_ev_timeout = (r_cycle_cnt == c_TIMEOUT_LAST);
    assign w_rst_last   = (r_rst_cnt == c_RST_LAST);
    assign w_drain_last = (r_drain_cnt == c_DRAIN_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; error outranks every other terminal event
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_RESET: begin
                if (w_rst_last) begin
                    w_next_state = c_S_RUN;
                end
            end
            c_S_RUN: begin
                if (w_ev_err) begin
                    w_next_state = c_DRAIN_EN ? c_S_DRAIN : c_S_DONE;
                end else if (halt || w_ev_stall || w_ev_timeout) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DRAIN: begin
                if (w_drain_last) begin
                    w_next_state = c_S_DONE;
                end
            end
            c_S_DONE: begin
                w_next_state = c_S_DONE;
            end
            default: begin
                w_next_state = c_S_RESET;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs
    // change on the same edge as the state itself
    always_comb begin
        w_dut_rst_nxt = (w_next_state == c_S_RESET);
        w_run_nxt     = (w_next_state == c_S_RUN);
        w_done_nxt    = (w_next_state == c_S_DONE);
    end

    // Registered control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dut_rst <= 1'b1;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_dut_rst <= w_dut_rst_nxt;
            r_run     <= w_run_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Status and error capture; written only from RUN so the first
    // terminal event is held through DRAIN and DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status  <= c_ST_RUNNING;
            r_err_src <= '0;
        end else if (w_in_run) begin
            if (w_ev_err) begin
                r_status  <= c_ST_ERROR;
                r_err_src <= err;
            end else if (halt) begin
                r_status <= c_ST_PASS;
            end else if (w_ev_stall) begin
                r_status <= c_ST_STALL;
            end else if (w_ev_timeout) begin
                r_status <= c_ST_TIMEOUT;
            end
        end
    end

    // Reset-hold counter: counts edges spent in RESET after rst release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rst_cnt <= '0;
        end else if ((r_state == c_S_RESET) && !w_rst_last) begin
            r_rst_cnt <= r_rst_cnt + c_RST_ONE;
        end
    end

    // Stall counter: consecutive commit-free RUN cycles, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_in_run) begin
            if (commit_valid) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != c_STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + c_STALL_ONE;
            end
        end
    end

    // Drain counter: cycles spent in DRAIN, idle at zero elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (r_state == c_S_DRAIN) begin
            if (!w_drain_last) begin
                r_drain_cnt <= r_drain_cnt + c_DRAIN_ONE;
            end
        end else begin
            r_drain_cnt <= '0;
        end
    end

    // Run statistics: saturating cycle and commit counters over RUN+DRAIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt  <= '0;
            r_commit_cnt <= '0;
        end else if (w_counting) begin
            if (r_cycle_cnt != c_CNT_MAX) begin
                r_cycle_cnt <= r_cycle_cnt + c_CNT_ONE;
            end
            if (commit_valid && (r_commit_cnt != c_CNT_MAX)) begin
                r_commit_cnt <= r_commit_cnt + c_CNT_ONE;
            end
        end
    end

    assign dut_rst      = r_dut_rst;
    assign run          = r_run;
    assign done         = r_done;
    assign status       = r_status;
    assign err_src      = r_err_src;
    assign cycle_count  = r_cycle_cnt;
    assign commit_count = r_commit_cnt;

endmodule
`default_nettype wire
